sram_addr_gen: RTL

SRAM_ADDR_GEN -- requirements
Module: sram_addr_gen

---
 rtl/sram_addr_gen_if.sv | 34 +++
 rtl/sram_addr_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sram_addr_gen_if.sv
// Control/status bundle for the multi-channel SRAM address generator.
// master drives commands and configuration; slave is the generator.
interface sram_addr_gen_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 13
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     clear;
  logic [CH_W-1:0]          ch_sel;
  logic                     start;
  logic                     wrap_en;
  logic                     req;
  logic [CNT_W-1:0]         image_width;
  logic [CNT_W-1:0]         image_height;
  logic [NUM_CH*ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0]        sram_addr;
  logic                     addr_valid;
  logic [NUM_CH-1:0]        ch_busy;
  logic [NUM_CH-1:0]        row_done;
  logic [NUM_CH-1:0]        frame_done;
  logic                     err;

  modport master (
    output clear, ch_sel, start, wrap_en, req, image_width, image_height, base_addr,
    input  sram_addr, addr_valid, ch_busy, row_done, frame_done, err
  );

  modport slave (
    input  clear, ch_sel, start, wrap_en, req, image_width, image_height, base_addr,
    output sram_addr, addr_valid, ch_busy, row_done, frame_done, err
  );
endinterface

// File: rtl/sram_addr_gen.sv
// Multi-channel raster address generator: each channel walks base + row*width + col
// over a width x height frame, one address per accepted request.

module sram_addr_ch #(
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              arm,
  input  logic              kill,
  input  logic              step,
  input  logic              wrap_en,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  height,
  input  logic [ADDR_W-1:0] base,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              col_last,
  output logic              row_last
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base_q, row_base;
  logic [CNT_W-1:0]   w_q, h_q, col, row;
  logic               wrap_q;

  assign busy     = (state == ACTIVE);
  // row_base accumulates width so no multiplier is needed; overflow wraps mod 2^ADDR_W
  assign addr     = base_q + row_base + ADDR_W'(col);
  assign col_last = (col == w_q - CNT_W'(1));
  assign row_last = (row == h_q - CNT_W'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      base_q   <= '0;
      w_q      <= '0;
      h_q      <= '0;
      wrap_q   <= 1'b0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (clear) begin
      state    <= IDLE;
      base_q   <= '0;
      w_q      <= '0;
      h_q      <= '0;
      wrap_q   <= 1'b0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (arm) begin
      state    <= ACTIVE;
      base_q   <= base;
      w_q      <= width;
      h_q      <= height;
      wrap_q   <= wrap_en;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (kill) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (step) begin
      if (!col_last) begin
        col <= col + CNT_W'(1);
      end else begin
        col <= '0;
        if (row_last) begin
          row      <= '0;
          row_base <= '0;
          state    <= wrap_q ? ACTIVE : IDLE;
        end else begin
          row      <= row + CNT_W'(1);
          row_base <= row_base + ADDR_W'(w_q);
        end
      end
    end
  end
endmodule

module sram_addr_gen #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 13
) (
  input  logic          clk,
  input  logic          n_rst,
  sram_addr_gen_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]              sel_oh, arm, kill, step, busy, c_last, r_last;
  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr;
  logic                           sel_ok, cfg_ok, req_acc, err_set;
  logic [ADDR_W-1:0]              sel_addr;
  logic                           sel_col_last, sel_row_last;

  // Out-of-range selects decode to an all-zero one-hot, which is the legality test
  assign sel_ok = |sel_oh;
  assign cfg_ok = (bus.image_width != '0) && (bus.image_height != '0);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sel_oh[k] = (bus.ch_sel == CH_W'(k));
    assign arm[k]    = bus.start & sel_oh[k] & cfg_ok;
    assign kill[k]   = bus.start & sel_oh[k] & ~cfg_ok;
    assign step[k]   = bus.req & ~bus.start & sel_oh[k] & busy[k];

    sram_addr_ch #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear    (bus.clear),
      .arm      (arm[k]),
      .kill     (kill[k]),
      .step     (step[k]),
      .wrap_en  (bus.wrap_en),
      .width    (bus.image_width),
      .height   (bus.image_height),
      .base     (bus.base_addr[k*ADDR_W +: ADDR_W]),
      .busy     (busy[k]),
      .addr     (ch_addr[k]),
      .col_last (c_last[k]),
      .row_last (r_last[k])
    );
  end

  assign req_acc = |step;
  // start outranks req, so a req is only judged when start is low
  assign err_set = (bus.start & ~(sel_ok & cfg_ok))
                 | (bus.req & ~bus.start & ~(|(sel_oh & busy)));

  always_comb begin
    sel_addr     = '0;
    sel_col_last = 1'b0;
    sel_row_last = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_oh[k]) begin
        sel_addr     = ch_addr[k];
        sel_col_last = c_last[k];
        sel_row_last = r_last[k];
      end
    end
  end

  assign bus.ch_busy = busy;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.sram_addr  <= '0;
      bus.addr_valid <= 1'b0;
      bus.row_done   <= '0;
      bus.frame_done <= '0;
      bus.err        <= 1'b0;
    end else if (bus.clear) begin
      bus.sram_addr  <= '0;
      bus.addr_valid <= 1'b0;
      bus.row_done   <= '0;
      bus.frame_done <= '0;
      bus.err        <= 1'b0;
    end else begin
      bus.addr_valid <= req_acc;
      bus.row_done   <= '0;
      bus.frame_done <= '0;
      if (req_acc) begin
        bus.sram_addr  <= sel_addr;
        bus.row_done   <= sel_oh & {NUM_CH{sel_col_last}};
        bus.frame_done <= sel_oh & {NUM_CH{sel_col_last & sel_row_last}};
      end
      if (err_set) bus.err <= 1'b1;
    end
  end
endmodule
